insmem_rom: RTL and testbench
=============================

Name: insmem_rom

Overview:
- Word-addressed instruction memory for the RV32 single-cycle/fetch datapath. It is fed directly by the program counter, which increments by 1 per instruction, so `pc` is a word index, not a byte address.
- Returns the 32-bit instruction at `pc` through a registered (synchronous) read port.
- Powers up holding a fixed built-in RV32I test program.
- Provides a write port so a bench can load a different program.

Parameters:
- DEPTH, 256, number of 32-bit instruction words.
- ADDR_W, 8, index bits used, equal to log2(DEPTH).
- NOP_WORD, 32'h00000013, the RV32I `addi x0,x0,0` value returned for reset, out-of-range and unprogrammed words.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  word index of the instruction to fetch.
- `ins`  out  32  registered instruction word.
- `we`  in  1  write enable for program load; tie to 0 when unused.
- `waddr`  in  ADDR_W  word index to write.
- `wdata`  in  32  instruction word to write.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset:
  - On a rising edge with `rst`=1, `ins` <= NOP_WORD.
  - The read is suppressed during reset.
  - Memory contents are NOT cleared by reset.
  - The write port still operates during reset.
- Read:
  - On each rising edge with `rst`=0, `ins` <= mem[`pc`[ADDR_W-1:0]] when `pc` < DEPTH.
  - If `pc` >= DEPTH (any upper bit set), `ins` <= NOP_WORD. There is no wrap-around.
  - Latency is exactly 1 cycle. `ins` holds its value between edges.
- Write:
  - On a rising edge with `we`=1, mem[`waddr`] <= `wdata`.
- Same-edge read and write to the same word: read-before-write. `ins` gets the old word; the new word is visible on the next read.
- Initial contents (simulation start and FPGA config), word index: value:
  - 0: 00500093 (addi x1,x0,5)
  - 1: 00300113 (addi x2,x0,3)
  - 2: 002081B3 (add x3,x1,x2)
  - 3: 40208233 (sub x4,x1,x2)
  - 4: 0020F2B3 (and x5,x1,x2)
  - 5: 0020E333 (or x6,x1,x2)
  - 6: 0020C3B3 (xor x7,x1,x2)
  - 7: 00302023 (sw x3,0(x0))
  - 8: 00002403 (lw x8,0(x0))
  - 9..DEPTH-1: NOP_WORD.
- Before the first clock edge, `ins` = NOP_WORD (register initial value), so the output is never X.
- Pure combinational decode of `pc` feeds a single output register. No handshake: every cycle is a valid fetch.

Test Plan:
- Reset, then `pc` 0,1,2,3 on consecutive edges -> `ins` shows 00500093, 00300113, 002081B3, 40208233, each one edge after its `pc`.
- Hold `rst`=1 for 2 cycles with `pc`=2 -> `ins`=00000013 throughout. First edge after `rst` falls -> `ins`=002081B3.
- `pc`=9, then 255, then 256, then 32'hFFFFFFFF -> `ins`=00000013 each time (unprogrammed, last word, and out-of-range cases).
- `we`=1, `waddr`=9, `wdata`=DEADBEEF with `pc`=9 on the same edge -> `ins`=00000013 (old value). Next edge with `pc`=9 -> DEADBEEF.
- Write 12345678 to word 0, then pulse `rst`, then read `pc`=0 -> `ins`=12345678 (reset does not clear memory).
- Counter-style fetch: `pc` incrementing 0..12 from reset -> `ins` sequence matches the table above, then 00000013 for indices 9..12.

Source files
------------

// File: rtl/insmem_rom.sv
// insmem_rom: word-addressed RV32 instruction memory with one registered read port
// and one write port for loading a program.
//
// The program counter feeds this block directly and steps by 1 per instruction,
// so `pc` is a word index, not a byte address. After power-up or FPGA
// configuration the memory holds a short built-in RV32I test program.
//
// Ports:
//   clk    in   1       single clock; all state changes on its rising edge
//   rst    in   1       synchronous, active-high; forces `ins` to NOP_WORD
//   pc     in   32      word index to fetch; any index >= DEPTH reads NOP_WORD
//   ins    out  32      registered instruction word, one cycle after `pc`
//   we     in   1       write enable for program load (tie to 0 when unused)
//   waddr  in   ADDR_W  word index to write
//   wdata  in   32      instruction word to write
module insmem_rom #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic [31:0]       ins,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata
);

  // The declaration initialiser sets the power-up / configuration image.
  // Reset never touches this array.
  logic [31:0] mem [0:DEPTH-1] = '{
    0:       32'h00500093,  // addi x1,x0,5
    1:       32'h00300113,  // addi x2,x0,3
    2:       32'h002081B3,  // add  x3,x1,x2
    3:       32'h40208233,  // sub  x4,x1,x2
    4:       32'h0020F2B3,  // and  x5,x1,x2
    5:       32'h0020E333,  // or   x6,x1,x2
    6:       32'h0020C3B3,  // xor  x7,x1,x2
    7:       32'h00302023,  // sw   x3,0(x0)
    8:       32'h00002403,  // lw   x8,0(x0)
    default: NOP_WORD
  };

  // Starts at NOP_WORD so `ins` is defined before the first clock edge.
  logic [31:0] ins_reg = NOP_WORD;

  // There is no wrap-around: any set bit above the index field means the
  // fetch is out of range.
  logic pc_in_range;
  assign pc_in_range = (pc[31:ADDR_W] == '0);

  // The read and the write are both nonblocking on the same edge. A read and
  // a write to the same word on one edge therefore return the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (rst) begin
      ins_reg <= NOP_WORD;
    end else if (pc_in_range) begin
      ins_reg <= mem[pc[ADDR_W-1:0]];
    end else begin
      ins_reg <= NOP_WORD;
    end
  end

  assign ins = ins_reg;

endmodule

// File: tb/tb_insmem_rom.sv
// tb_insmem_rom: scoreboard bench for insmem_rom.
//
// The stimulus process applies one transaction per clock on the falling edge.
// It uses a plain array model of the memory to work out the expected `ins` and
// pushes that value into a queue. The monitor samples `ins` shortly after each
// rising edge, pops the queue and compares.
module tb_insmem_rom;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] ins;
  logic        we = 1'b0;
  logic [7:0]  waddr = '0;
  logic [31:0] wdata = '0;

  insmem_rom dut (
    .clk   (clk),
    .rst   (rst),
    .pc    (pc),
    .ins   (ins),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  always #5 clk = ~clk;

  // Reference memory: the built-in program, with NOP everywhere else.
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          checks = 0;
  int          passed = 0;
  bit          stim_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
      $display("[%0t] %s ins=%08h ok", $time, tag, got);
    end else begin
      $display("[%0t] FAIL %s ins=%08h expected=%08h", $time, tag, got, exp);
    end
  endtask

  // One transaction: drive the inputs, work out the fetch result from the
  // current model contents, then apply the write to the model. This ordering
  // gives read-before-write on a same-word collision.
  task automatic step(input logic r, input logic [31:0] p, input logic w,
                      input logic [7:0] wa, input logic [31:0] wd, input string tag);
    logic [31:0] e;
    @(negedge clk);
    rst = r; pc = p; we = w; waddr = wa; wdata = wd;
    if (r)             e = NOP;
    else if (p < 256)  e = model[p];
    else               e = NOP;
    if (w) model[wa] = wd;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic rd(input logic [31:0] p, input string tag);
    step(1'b0, p, 1'b0, 8'd0, 32'd0, tag);
  endtask

  // Monitor: compares one queued expectation after each rising edge.
  initial begin
    #1 check("power_up", ins, NOP);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), ins, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] p, wd;
    logic [7:0]  wa;
    logic        r, w;
    int          sel;
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    model[0] = 32'h00500093; model[1] = 32'h00300113; model[2] = 32'h002081B3;
    model[3] = 32'h40208233; model[4] = 32'h0020F2B3; model[5] = 32'h0020E333;
    model[6] = 32'h0020C3B3; model[7] = 32'h00302023; model[8] = 32'h00002403;

    // Fetch straight after reset.
    step(1'b1, 32'd0, 1'b0, 8'd0, 32'd0, "reset");
    for (int i = 0; i < 4; i++) rd(i, $sformatf("fetch_pc%0d", i));

    // Reset held for two cycles with pc=2, then the first fetch after it.
    step(1'b1, 32'd2, 1'b0, 8'd0, 32'd0, "rst_hold1");
    step(1'b1, 32'd2, 1'b0, 8'd0, 32'd0, "rst_hold2");
    rd(32'd2, "after_rst_pc2");

    // Unprogrammed word, last word, and two out-of-range indices.
    rd(32'd9, "pc9_unprog");
    rd(32'd255, "pc255_last");
    rd(32'd256, "pc256_oor");
    rd(32'hFFFFFFFF, "pcmax_oor");

    // Counter-style fetch of 0..12 from reset.
    step(1'b1, 32'd0, 1'b0, 8'd0, 32'd0, "reset2");
    for (int i = 0; i <= 12; i++) rd(i, $sformatf("count_pc%0d", i));

    // Read and write to the same word on one edge, then read the new word.
    step(1'b0, 32'd9, 1'b1, 8'd9, 32'hDEADBEEF, "rbw_old");
    rd(32'd9, "rbw_new");

    // A write to word 0 must survive a reset.
    step(1'b0, 32'd5, 1'b1, 8'd0, 32'h12345678, "wr_w0");
    step(1'b1, 32'd0, 1'b0, 8'd0, 32'd0, "rst_pulse");
    rd(32'd0, "w0_kept");

    // A write issued while reset is asserted still takes effect.
    step(1'b1, 32'd20, 1'b1, 8'd20, 32'hCAFEF00D, "wr_in_rst");
    rd(32'd20, "rd_wr_in_rst");

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       p = $urandom_range(0, 15);
        1:       p = $urandom_range(0, 255);
        2:       p = $urandom_range(256, 1023);
        default: p = $urandom;
      endcase
      r  = ($urandom_range(0, 15) == 0);
      w  = ($urandom_range(0, 3) == 0);
      wa = ($urandom_range(0, 1) == 0) ? p[7:0] : 8'($urandom_range(0, 15));
      wd = $urandom;
      step(r, p, w, wa, wd, $sformatf("rand%0d", n));
    end

    @(negedge clk);
    we = 1'b0;
    stim_done = 1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
